// File: rtl/cdb_pkg.sv
// Shared types and defaults for the common data bus: result/write-port formats and widths.
package cdb_pkg;

    localparam int unsigned PRN_W          = 6;
    localparam int unsigned DATA_W         = 32;
    localparam int unsigned CDB_N          = 2;
    localparam int unsigned NUM_FU_DEFAULT = 4;

    typedef logic [PRN_W-1:0]  prn_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef struct packed {
        prn_t  prn;
        data_t value;
    } fu_result_t;

    typedef struct packed {
        prn_t  prn;
        data_t value;
    } prf_write_t;

    function automatic int unsigned ptr_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdb_if.sv
// FU-to-CDB handshake and CDB write-back bus; master drives results, slave is the CDB.
interface cdb_if import cdb_pkg::*; #(
    parameter int unsigned NUM_FU = NUM_FU_DEFAULT,
    parameter int unsigned WIDTH  = CDB_N
) ();

    logic       [NUM_FU-1:0]            fu_valid;
    fu_result_t [NUM_FU-1:0]            fu_result;
    logic       [NUM_FU-1:0]            fu_ready;
    logic                               squash;
    prf_write_t [WIDTH-1:0]             prf_write;
    prn_t       [WIDTH-1:0]             cdb_tag;
    logic       [$clog2(NUM_FU+1)-1:0]  occupancy;

    modport master (
        output fu_valid, fu_result, squash,
        input  fu_ready, prf_write, cdb_tag, occupancy
    );

    modport slave (
        input  fu_valid, fu_result, squash,
        output fu_ready, prf_write, cdb_tag, occupancy
    );

endinterface

// File: rtl/cdb_rr_select.sv
// Round-robin multi-grant selector: grants up to WIDTH requesters starting at ptr, one-hot per slot.
module rr_select #(
    parameter int unsigned N     = 4,
    parameter int unsigned WIDTH = 2,
    parameter int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]            req,
    input  logic [PTR_W-1:0]        ptr,
    output logic [WIDTH-1:0][N-1:0] grant
);

    always_comb begin
        int unsigned taken;
        grant = '0;
        taken = 0;
        // Visit positions ptr, ptr+1, ... (mod N); the k-th hit lands in slot k.
        for (int unsigned k = 0; k < N; k++) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (i == (32'(ptr) + k) % N && req[i]) begin
                    for (int unsigned s = 0; s < WIDTH; s++) begin
                        if (s == taken) grant[s][i] = 1'b1;
                    end
                    taken++;
                end
            end
        end
    end

endmodule

// File: rtl/cdb.sv
// Common data bus: one holding entry per FU, up to WIDTH round-robin write-backs per cycle.
module cdb import cdb_pkg::*; #(
    parameter int unsigned NUM_FU = NUM_FU_DEFAULT,
    parameter int unsigned WIDTH  = CDB_N
) (
    input  logic  clock,
    input  logic  reset,
    cdb_if.slave  bus
);

    localparam int unsigned PTR_W = ptr_width(NUM_FU);
    localparam int unsigned OCC_W = $clog2(NUM_FU + 1);

    logic       [NUM_FU-1:0]            valid_q, valid_d;
    fu_result_t [NUM_FU-1:0]            entry_q, entry_d;
    logic       [PTR_W-1:0]             rr_ptr_q, rr_ptr_d;

    logic       [NUM_FU-1:0]            req;
    logic       [WIDTH-1:0][NUM_FU-1:0] grant;
    logic       [NUM_FU-1:0]            granted;
    logic       [NUM_FU-1:0]            ready;
    logic                               any_grant;
    logic       [PTR_W-1:0]             last_idx;
    prf_write_t [WIDTH-1:0]             wr;
    logic       [OCC_W-1:0]             occ;

    // A squash suppresses every grant, which zeroes the outputs and freezes rr_ptr.
    assign req = bus.squash ? '0 : valid_q;

    rr_select #(
        .N     (NUM_FU),
        .WIDTH (WIDTH),
        .PTR_W (PTR_W)
    ) u_rr_select (
        .req   (req),
        .ptr   (rr_ptr_q),
        .grant (grant)
    );

    always_comb begin
        granted   = '0;
        any_grant = 1'b0;
        last_idx  = rr_ptr_q;
        wr        = '0;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                if (grant[k][i]) begin
                    granted[i] = 1'b1;
                    any_grant  = 1'b1;
                    last_idx   = PTR_W'(i);
                    wr[k]      = entry_q[i];
                end
            end
        end
    end

    assign ready = {NUM_FU{bus.squash}} | ~valid_q | granted;

    always_comb begin
        occ = '0;
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            occ = occ + OCC_W'(valid_q[i]);
        end
    end

    assign bus.fu_ready  = ready;
    assign bus.prf_write = wr;
    assign bus.occupancy = occ;

    always_comb begin
        for (int unsigned k = 0; k < WIDTH; k++) begin
            bus.cdb_tag[k] = wr[k].prn;
        end
    end

    always_comb begin
        valid_d  = valid_q;
        entry_d  = entry_q;
        rr_ptr_d = rr_ptr_q;
        if (bus.squash) begin
            valid_d = '0;
        end else begin
            if (any_grant) begin
                rr_ptr_d = (last_idx == PTR_W'(NUM_FU - 1)) ? '0 : last_idx + PTR_W'(1);
            end
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                if (granted[i]) valid_d[i] = 1'b0;
                // prn 0 carries nothing to write back, so it is accepted and dropped.
                if (bus.fu_valid[i] && ready[i] && bus.fu_result[i].prn != '0) begin
                    valid_d[i] = 1'b1;
                    entry_d[i] = bus.fu_result[i];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q  <= '0;
            entry_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            valid_q  <= valid_d;
            entry_q  <= entry_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule
